// File: rtl/instr_sequencer.sv
// Two-cycle FETCH/EXECUTE sequencer for the 8-bit CPU.
// Drives rom_address from pc, captures ir, decodes it.
module instr_sequencer #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       run,
  output logic [7:0] rom_address,
  input  logic [7:0] rom_data,
  input  logic [7:0] jump_target,
  input  logic [7:0] cond_value,
  output logic [7:0] pc,
  output logic [7:0] imm_out,
  output logic [2:0] src_sel,
  output logic [2:0] dst_sel,
  output logic [1:0] wb_src,
  output logic [2:0] alu_op,
  output logic       wr_en,
  output logic       jump_taken,
  output logic       exec
);

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;

  logic       is_exec;
  logic       is_jmp;
  logic       cond_ok;
  logic       take;
  logic       neg;
  logic       zero;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign is_exec = (state_q == EXECUTE);
  assign is_jmp  = (ir_q[7:6] == 2'b11);
  assign neg     = cond_value[7];
  assign zero    = (cond_value == 8'h00);

  always_comb begin
    cond_ok = 1'b0;
    unique case (ir_q[2:0])
      3'b000: cond_ok = 1'b0;
      3'b001: cond_ok = zero;
      3'b010: cond_ok = neg;
      3'b011: cond_ok = neg | zero;
      3'b100: cond_ok = 1'b1;
      3'b101: cond_ok = ~zero;
      3'b110: cond_ok = ~neg;
      3'b111: cond_ok = ~neg & ~zero;
      default: cond_ok = 1'b0;
    endcase
  end

  assign take = is_exec & is_jmp & cond_ok;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        state_d = FETCH;
        pc_d    = take ? jump_target
                       : pc_q + 8'd1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes are masked by reset so a reset
  // landing in EXECUTE commits nothing.
  always_comb begin
    src_sel    = 3'b000;
    dst_sel    = 3'b000;
    wb_src     = 2'b00;
    alu_op     = 3'b000;
    wr_en      = 1'b0;
    jump_taken = take & reset_n;
    exec       = is_exec & reset_n;
    if (is_exec) begin
      unique case (ir_q[7:6])
        2'b00: begin
          dst_sel = 3'b000;
          wb_src  = 2'b00;
          wr_en   = reset_n;
        end
        2'b01: begin
          dst_sel = 3'b011;
          wb_src  = 2'b01;
          alu_op  = ir_q[2:0];
          wr_en   = reset_n;
        end
        2'b10: begin
          src_sel = ir_q[5:3];
          dst_sel = ir_q[2:0];
          wb_src  = 2'b10;
          wr_en   = reset_n;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  assign rom_address = pc_q;
  assign pc          = pc_q;
  assign imm_out     = {2'b00, ir_q[5:0]};

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: vector table,
// condition sweep, stall, wrap and reset cases.
module tb_instr_sequencer;

  logic       clk;
  logic       reset_n;
  logic       run;
  logic [7:0] rom_address;
  logic [7:0] rom_data;
  logic [7:0] jump_target;
  logic [7:0] cond_value;
  logic [7:0] pc;
  logic [7:0] imm_out;
  logic [2:0] src_sel;
  logic [2:0] dst_sel;
  logic [1:0] wb_src;
  logic [2:0] alu_op;
  logic       wr_en;
  logic       jump_taken;
  logic       exec;

  logic [7:0] mem [256];

  assign rom_data = mem[rom_address];

  instr_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .run(run),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .jump_target(jump_target),
    .cond_value(cond_value),
    .pc(pc),
    .imm_out(imm_out),
    .src_sel(src_sel),
    .dst_sel(dst_sel),
    .wb_src(wb_src),
    .alu_op(alu_op),
    .wr_en(wr_en),
    .jump_taken(jump_taken),
    .exec(exec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       wr;
    logic       jmp;
    logic [2:0] src;
    logic [2:0] dst;
    logic [2:0] alu;
    logic [1:0] wb;
    logic [7:0] imm;
    logic [7:0] nxt;
  } exp_t;

  typedef struct packed {
    logic [7:0] instr;
    logic [7:0] jt;
    logic [7:0] cv;
    exp_t       e;
  } vec_t;

  int   n_cmp;
  int   n_err;
  logic [7:0] pc_m;
  exp_t q[$];
  vec_t tab [11];
  logic [7:0] cvals [5];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic logic cond_m(
      input logic [2:0] code,
      input logic [7:0] cv);
    int v;
    v = $signed(cv);
    case (code)
      3'd0: return 1'b0;
      3'd1: return v == 0;
      3'd2: return v < 0;
      3'd3: return v <= 0;
      3'd4: return 1'b1;
      3'd5: return v != 0;
      3'd6: return v >= 0;
      default: return v > 0;
    endcase
  endfunction

  function automatic exp_t model(
      input logic [7:0] instr,
      input logic [7:0] cur,
      input logic [7:0] jt,
      input logic [7:0] cv);
    exp_t e;
    logic t;
    e = '0;
    t = 1'b0;
    e.imm = {2'b00, instr[5:0]};
    case (instr[7:6])
      2'b00: e.wr = 1'b1;
      2'b01: begin
        e.wr = 1'b1; e.dst = 3'd3;
        e.wb = 2'b01; e.alu = instr[2:0];
      end
      2'b10: begin
        e.wr = 1'b1; e.src = instr[5:3];
        e.dst = instr[2:0]; e.wb = 2'b10;
      end
      default: t = cond_m(instr[2:0], cv);
    endcase
    e.jmp = t;
    e.nxt = t ? jt : cur + 8'd1;
    return e;
  endfunction

  task automatic do_instr(input logic [7:0] instr,
                          input logic [7:0] jt,
                          input logic [7:0] cv,
                          input exp_t e,
                          input bit drop_run);
    exp_t g;
    mem[pc_m] = instr;
    jump_target = jt;
    cond_value = cv;
    run = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      g = q.pop_front();
      chk("exec", {31'd0, exec}, 1);
      chk("wr_en", {31'd0, wr_en}, {31'd0, g.wr});
      chk("jump_taken", {31'd0, jump_taken},
          {31'd0, g.jmp});
      chk("src_sel", {29'd0, src_sel}, {29'd0, g.src});
      chk("dst_sel", {29'd0, dst_sel}, {29'd0, g.dst});
      chk("alu_op", {29'd0, alu_op}, {29'd0, g.alu});
      chk("wb_src", {30'd0, wb_src}, {30'd0, g.wb});
      chk("imm_out", {24'd0, imm_out}, {24'd0, g.imm});
      pc_m = g.nxt;
    end
    if (drop_run) run = 1'b0;
    @(posedge clk); #1;
    chk("next_addr", {24'd0, rom_address},
        {24'd0, pc_m});
    chk("fetch_wr", {30'd0, wr_en, exec}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tab[0]  = '{8'h05, 8'h00, 8'h00,
      '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h05, 8'h01}};
    tab[1]  = '{8'h99, 8'h00, 8'h00,
      '{1'b1, 1'b0, 3'd3, 3'd1, 3'd0, 2'd2, 8'h19, 8'h02}};
    tab[2]  = '{8'h45, 8'h00, 8'h00,
      '{1'b1, 1'b0, 3'd0, 3'd3, 3'd5, 2'd1, 8'h05, 8'h03}};
    tab[3]  = '{8'hC1, 8'h00, 8'h00,
      '{1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 2'd0, 8'h01, 8'h00}};
    tab[4]  = '{8'hC1, 8'h00, 8'h01,
      '{1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h01, 8'h01}};
    tab[5]  = '{8'h43, 8'h00, 8'h00,
      '{1'b1, 1'b0, 3'd0, 3'd3, 3'd3, 2'd1, 8'h03, 8'h02}};
    tab[6]  = '{8'hC4, 8'hFE, 8'h00,
      '{1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 2'd0, 8'h04, 8'hFE}};
    tab[7]  = '{8'h3F, 8'h00, 8'h00,
      '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'd0, 8'h3F, 8'hFF}};
    tab[8]  = '{8'h80, 8'h00, 8'h00,
      '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 2'd2, 8'h00, 8'h00}};
    tab[9]  = '{8'hC4, 8'h00, 8'h00,
      '{1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 2'd0, 8'h04, 8'h00}};
    tab[10] = '{8'hC7, 8'h00, 8'h01,
      '{1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 2'd0, 8'h07, 8'h00}};
    cvals[0] = 8'h80;
    cvals[1] = 8'hFF;
    cvals[2] = 8'h00;
    cvals[3] = 8'h01;
    cvals[4] = 8'h7F;

    reset_n = 1'b0;
    run = 1'b0;
    jump_target = 8'h00;
    cond_value = 8'h00;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_addr", {24'd0, rom_address}, 0);
    chk("rst_pc", {24'd0, pc}, 0);
    chk("rst_strobes",
        {29'd0, wr_en, jump_taken, exec}, 0);
    chk("rst_decode",
        {21'd0, src_sel, dst_sel, wb_src, alu_op}, 0);
    chk("rst_imm", {24'd0, imm_out}, 0);
    reset_n = 1'b1;
    pc_m = 8'h00;

    for (int i = 0; i < 11; i++)
      do_instr(tab[i].instr, tab[i].jt,
               tab[i].cv, tab[i].e, 1'b0);

    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 5; k++) begin
        logic [7:0] ins;
        ins = {5'b11000, c[2:0]};
        do_instr(ins, 8'h20, cvals[k],
                 model(ins, pc_m, 8'h20, cvals[k]),
                 1'b0);
      end
    end

    do_instr(8'h2A, 8'h00, 8'h00,
             model(8'h2A, pc_m, 8'h00, 8'h00), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_pc", {24'd0, pc}, {24'd0, pc_m});
      chk("hold_ir", {24'd0, imm_out}, 32'h2A);
      chk("hold_strobes", {30'd0, wr_en, exec}, 0);
    end

    mem[pc_m] = 8'h9A;
    run = 1'b1;
    @(posedge clk); #1;
    chk("rx_exec", {31'd0, exec}, 1);
    reset_n = 1'b0;
    #1;
    chk("rx_wr_en", {31'd0, wr_en}, 0);
    chk("rx_strobes", {30'd0, jump_taken, exec}, 0);
    run = 1'b0;
    @(posedge clk); #1;
    chk("rx_addr", {24'd0, rom_address}, 0);
    chk("rx_fetch", {31'd0, exec}, 0);
    reset_n = 1'b1;
    pc_m = 8'h00;
    do_instr(8'h01, 8'h00, 8'h00,
             model(8'h01, pc_m, 8'h00, 8'h00), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
